// File: rtl/l2_writeback_buffer_if.sv
// Line-granular request/response bus shared by the L2 side and the burst adaptor side of the write-back buffer.
// master drives the request fields, slave returns read data and the completion pulse.
interface l2_writeback_buffer_if #(
  parameter int LINE_W = 256
);
  logic [31:0]       address;
  logic              read;
  logic              write;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output address, read, write, wdata, input rdata, resp);
  modport slave  (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/l2_writeback_buffer.sv
// Write-back FIFO between the L2 memory port and the burst cacheline adaptor; forwards read hits, drains when idle.
// Optional feature: define WBBUF_COALESCE_EN to merge writes into a buffered entry with the same tag.
module l2_writeback_buffer #(
  parameter int LINE_W = 256,
  parameter int OFFSET = 5,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  l2_writeback_buffer_if.slave   mem,
  l2_writeback_buffer_if.master  pmem
);
  localparam int TAG_W = 32 - OFFSET;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
`ifdef WBBUF_COALESCE_EN
  localparam logic COALESCE_C = 1'b1;
`else
  localparam logic COALESCE_C = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP   = 2'd1,
    RD_MEM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag);
    return {tag, {OFFSET{1'b0}}};
  endfunction

  state_t            state_r;
  logic [TAG_W-1:0]  tag_r  [DEPTH];
  logic [LINE_W-1:0] line_r [DEPTH];
  logic [DEPTH-1:0]  valid_r;
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              mem_resp_r;
  logic [LINE_W-1:0] mem_rdata_r;
  logic              pmem_read_r;
  logic              pmem_write_r;
  logic [31:0]       pmem_address_r;

  logic [TAG_W-1:0]  req_tag_s;
  logic              hit_s;
  logic [PTR_W-1:0]  hit_idx_s;
  logic [PTR_W-1:0]  idx_s;
  logic              unused_s;

  assign req_tag_s = mem.address[31:OFFSET];
  assign unused_s  = ^mem.address[OFFSET-1:0];

  // Tag search walking oldest to youngest so the last match seen is the youngest copy
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {PTR_W{1'b0}};
    idx_s     = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_r + PTR_W'(i);
      if (valid_r[idx_s] && (tag_r[idx_s] == req_tag_s)) begin
        hit_s     = 1'b1;
        hit_idx_s = idx_s;
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Control FSM, FIFO storage and registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      valid_r        <= {DEPTH{1'b0}};
      head_r         <= {PTR_W{1'b0}};
      tail_r         <= {PTR_W{1'b0}};
      count_r        <= {CNT_W{1'b0}};
      mem_resp_r     <= 1'b0;
      mem_rdata_r    <= {LINE_W{1'b0}};
      pmem_read_r    <= 1'b0;
      pmem_write_r   <= 1'b0;
      pmem_address_r <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i]  <= {TAG_W{1'b0}};
        line_r[i] <= {LINE_W{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (mem.write && COALESCE_C && hit_s) begin
            line_r[hit_idx_s] <= mem.wdata;
            mem_resp_r        <= 1'b1;
            state_r           <= RESP;
          end else if (mem.write && (count_r < DEPTH_C)) begin
            tag_r[tail_r]   <= req_tag_s;
            line_r[tail_r]  <= mem.wdata;
            valid_r[tail_r] <= 1'b1;
            tail_r          <= tail_r + PTR_W'(1);
            count_r         <= count_r + CNT_W'(1);
            mem_resp_r      <= 1'b1;
            state_r         <= RESP;
          end else if (mem.write) begin
            // Full: make room first; the write is taken on the IDLE cycle after the drain
            pmem_write_r   <= 1'b1;
            pmem_address_r <= line_addr(tag_r[head_r]);
            state_r        <= DRAIN;
          end else if (mem.read && hit_s) begin
            mem_rdata_r <= line_r[hit_idx_s];
            mem_resp_r  <= 1'b1;
            state_r     <= RESP;
          end else if (mem.read) begin
            pmem_read_r    <= 1'b1;
            pmem_address_r <= line_addr(req_tag_s);
            state_r        <= RD_MEM;
          end else if (count_r != {CNT_W{1'b0}}) begin
            pmem_write_r   <= 1'b1;
            pmem_address_r <= line_addr(tag_r[head_r]);
            state_r        <= DRAIN;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_MEM: begin
          if (pmem.resp) begin
            mem_rdata_r <= pmem.rdata;
            pmem_read_r <= 1'b0;
            mem_resp_r  <= 1'b1;
            state_r     <= RESP;
          end else begin
            state_r <= RD_MEM;
          end
        end
        DRAIN: begin
          if (pmem.resp) begin
            valid_r[head_r] <= 1'b0;
            head_r          <= head_r + PTR_W'(1);
            count_r         <= count_r - CNT_W'(1);
            pmem_write_r    <= 1'b0;
            state_r         <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        RESP: begin
          mem_resp_r <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          mem_resp_r   <= 1'b0;
          pmem_read_r  <= 1'b0;
          pmem_write_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign mem.resp     = mem_resp_r;
  assign mem.rdata    = mem_rdata_r;
  assign pmem.read    = pmem_read_r;
  assign pmem.write   = pmem_write_r;
  assign pmem.address = pmem_address_r;
  assign pmem.wdata   = line_r[head_r];
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Self-checking bench: directed scenarios then random traffic against a queue/memory reference model.
module tb_l2_writeback_buffer;
  localparam int LINE_W = 256;
  localparam int OFFSET = 5;
  localparam int DEPTH  = 2;

  typedef struct {
    logic [26:0]  tag;
    logic [255:0] line;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  l2_writeback_buffer_if #(.LINE_W(LINE_W)) mem_bus ();
  l2_writeback_buffer_if #(.LINE_W(LINE_W)) pmem_bus ();

  l2_writeback_buffer #(.LINE_W(LINE_W), .OFFSET(OFFSET), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .mem(mem_bus), .pmem(pmem_bus)
  );

  ent_t         model_q[$];
  logic [255:0] mem_m[logic [26:0]];
  logic [31:0]  rd_log[$];
  logic [31:0]  wr_log[$];
  logic [255:0] wr_data_log[$];
  int total = 0, bad = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0, drain_done_cyc = 0, last_resp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_val(input logic [26:0] tag);
    if (mem_m.exists(tag)) return mem_m[tag];
    return {8{({5'b0, tag} ^ 32'h5A5A_0000)}};
  endfunction

  function automatic logic [255:0] expect_read(input logic [26:0] tag);
    for (int i = model_q.size() - 1; i >= 0; i--)
      if (model_q[i].tag == tag) return model_q[i].line;
    return mem_val(tag);
  endfunction

  function automatic bit is_buffered(input logic [26:0] tag);
    foreach (model_q[i]) if (model_q[i].tag == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_write(input logic [26:0] tag, input logic [255:0] line);
    ent_t e;
`ifdef WBBUF_COALESCE_EN
    for (int i = model_q.size() - 1; i >= 0; i--)
      if (model_q[i].tag == tag) begin
        model_q[i].line = line;
        return;
      end
`endif
    e.tag  = tag;
    e.line = line;
    model_q.push_back(e);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Burst memory responder: random latency, checks drain order against the model
  initial begin : responder
    int  wait_cnt;
    bit  armed;
    logic [26:0] t;
    armed = 1'b0;
    wait_cnt = 0;
    pmem_bus.resp  = 1'b0;
    pmem_bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        pmem_bus.resp = ~pmem_bus.resp;
        armed = 1'b0;
      end else if (pmem_bus.resp) begin
        pmem_bus.resp = 1'b0;
      end else if (pmem_bus.read || pmem_bus.write) begin
        if (!armed) begin
          armed = 1'b1;
          wait_cnt = $urandom_range(0, 3);
        end
        if (wait_cnt == 0) begin
          armed = 1'b0;
          t = pmem_bus.address[31:5];
          if (pmem_bus.write) begin
            wr_cnt++;
            wr_log.push_back(pmem_bus.address);
            wr_data_log.push_back(pmem_bus.wdata);
            if (model_q.size() > 0) begin
              check("drain_addr", pmem_bus.address, {model_q[0].tag, 5'b0});
              check("drain_data", pmem_bus.wdata, model_q[0].line);
              void'(model_q.pop_front());
            end else begin
              check("drain_unexpected", pmem_bus.write, 1'b0);
            end
            mem_m[t] = pmem_bus.wdata;
            drain_done_cyc = cyc + 1;
          end else begin
            rd_cnt++;
            rd_log.push_back(pmem_bus.address);
            check("rd_bypass_safe", is_buffered(t), 1'b0);
            check("rd_addr_align", pmem_bus.address[4:0], 5'b0);
            pmem_bus.rdata = mem_val(t);
          end
          pmem_bus.resp = 1'b1;
        end else begin
          wait_cnt--;
        end
      end else begin
        armed = 1'b0;
      end
    end
  end

  task automatic l2_req(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                        output int lat, output logic [255:0] rdata);
    bit got;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    mem_bus.address = addr;
    mem_bus.wdata   = data;
    mem_bus.write   = wr;
    mem_bus.read    = !wr;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (mem_bus.resp) begin
        got = 1'b1;
        break;
      end
    end
    check("resp_timeout", got, 1'b1);
    last_resp_cyc = cyc;
    rdata = mem_bus.rdata;
    mem_bus.read  = 1'b0;
    mem_bus.write = 1'b0;
    if (wr && got) model_write(addr[31:5], data);
    @(posedge clk);
    #1;
    check("resp_pulse", mem_bus.resp, 1'b0);
  endtask

  initial begin : main
    int lat, r0, w0;
    bit saw;
    logic [255:0] rd, exp, la, lb, lc;
    logic [31:0] addr;
    logic [26:0] tag;
    la = {8{32'hAAAA_0001}};
    lb = {8{32'hBBBB_0002}};
    lc = {8{32'hCCCC_0003}};
    mem_bus.address = 32'd0;
    mem_bus.wdata   = '0;
    mem_bus.read    = 1'b0;
    mem_bus.write   = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;

    // reset with pmem_resp toggling
    repeat (4) @(negedge clk);
    check("rst_mem_resp", mem_bus.resp, 1'b0);
    check("rst_mem_rdata", mem_bus.rdata, '0);
    check("rst_pmem_read", pmem_bus.read, 1'b0);
    check("rst_pmem_write", pmem_bus.write, 1'b0);
    check("rst_pmem_addr", pmem_bus.address, 32'd0);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("idle_no_pmem_read", pmem_bus.read, 1'b0);
      check("idle_no_pmem_write", pmem_bus.write, 1'b0);
    end

    // write then forwarded read
    l2_req(1'b1, 32'h0000_1000, la, lat, rd);
    check("wr_lat", lat, 1);
    r0 = rd_cnt;
    l2_req(1'b0, 32'h0000_1010, '0, lat, rd);
    check("hit_lat", lat, 1);
    check("hit_data", rd, la);
    check("hit_no_pmem_read", rd_cnt - r0, 0);

    // fill, then a write while full drains the oldest entry first
    l2_req(1'b1, 32'h0000_2000, lb, lat, rd);
    check("wr2_lat", lat, 1);
    w0 = wr_cnt;
    l2_req(1'b1, 32'h0000_3000, lc, lat, rd);
    check("full_drain_cnt", wr_cnt - w0, 1);
    check("full_drain_first", (wr_log.size() > w0) ? wr_log[w0] : 32'hFFFF_FFFF, 32'h0000_1000);
    check("full_resp_cyc", last_resp_cyc, drain_done_cyc + 1);

    // read miss bypasses the buffered lines, drain follows on the next idle cycle
    r0 = rd_cnt;
    w0 = wr_cnt;
    exp = expect_read(27'h200);
    l2_req(1'b0, 32'h0000_4000, '0, lat, rd);
    check("miss_data", rd, exp);
    check("miss_rd_cnt", rd_cnt - r0, 1);
    check("miss_rd_addr", (rd_log.size() > r0) ? rd_log[r0] : 32'hFFFF_FFFF, 32'h0000_4000);
    check("miss_before_drain", wr_cnt - w0, 0);
    @(posedge clk);
    #1;
    check("drain_after_miss", pmem_bus.write, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("drain_all_cnt", wr_cnt - w0, 2);
    check("drain_idle", pmem_bus.write, 1'b0);

    // same line written twice
    w0 = wr_cnt;
    l2_req(1'b1, 32'h0000_1000, la, lat, rd);
    l2_req(1'b1, 32'h0000_1000, lb, lat, rd);
    check("dup_wr_lat", lat, 1);
    l2_req(1'b0, 32'h0000_1000, '0, lat, rd);
    check("dup_read_lat", lat, 1);
    check("dup_read_data", rd, lb);
    repeat (30) @(posedge clk);
    #1;
`ifdef WBBUF_COALESCE_EN
    check("dup_drain_cnt", wr_cnt - w0, 1);
`else
    check("dup_drain_cnt", wr_cnt - w0, 2);
`endif
    check("dup_last_data", (wr_data_log.size() > 0) ? wr_data_log[wr_data_log.size() - 1] : '0, lb);

    // async reset while a drain is in flight
    l2_req(1'b1, 32'h0000_5000, lc, lat, rd);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (pmem_bus.write) begin
        saw = 1'b1;
        break;
      end
    end
    check("drain_seen", saw, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_pmem_write", pmem_bus.write, 1'b0);
    model_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_write", pmem_bus.write, 1'b0);
    check("post_rst_no_read", pmem_bus.read, 1'b0);
    r0 = rd_cnt;
    exp = mem_val(27'h280);
    l2_req(1'b0, 32'h0000_5000, '0, lat, rd);
    check("post_rst_miss", rd_cnt - r0, 1);
    check("post_rst_data", rd, exp);

    // random traffic over a small tag pool
    for (int n = 0; n < 160; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      tag  = 27'h400 + 27'($urandom_range(0, 5));
      addr = {tag, 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 99) < 55) begin
        l2_req(1'b1, addr, rand_line(), lat, rd);
      end else begin
        exp = expect_read(tag);
        l2_req(1'b0, addr, '0, lat, rd);
        check("rand_read", rd, exp);
      end
    end
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (model_q.size() == 0 && !pmem_bus.write) break;
    end
    check("final_drain", model_q.size(), 0);
    check("final_idle", pmem_bus.write, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
